// File: rtl/alu_share_arb_pkg.sv
package alu_share_arb_pkg;

  localparam int unsigned OP_BITS = 4;

  localparam logic [OP_BITS-1:0] aluPlus = 4'd0;
  localparam logic [OP_BITS-1:0] aluSub  = 4'd1;
  localparam logic [OP_BITS-1:0] aluAnd  = 4'd2;
  localparam logic [OP_BITS-1:0] aluOr   = 4'd3;
  localparam logic [OP_BITS-1:0] aluXor  = 4'd4;
  localparam logic [OP_BITS-1:0] aluSll  = 4'd5;
  localparam logic [OP_BITS-1:0] aluSrl  = 4'd6;
  localparam logic [OP_BITS-1:0] aluSra  = 4'd7;
  localparam logic [OP_BITS-1:0] aluSlt  = 4'd8;
  localparam logic [OP_BITS-1:0] aluSltu = 4'd9;
  localparam logic [OP_BITS-1:0] aluBEQ  = 4'd10;
  localparam logic [OP_BITS-1:0] aluBNE  = 4'd11;
  localparam logic [OP_BITS-1:0] aluBLT  = 4'd12;
  localparam logic [OP_BITS-1:0] aluBGE  = 4'd13;

  localparam int unsigned REQ_CORE = 0;
  localparam int unsigned REQ_FFT  = 1;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_FFT  = 1'b1
  } owner_e;

  function automatic logic is_branch_op(input logic [OP_BITS-1:0] op);
    return (op == aluBEQ) || (op == aluBNE) || (op == aluBLT) || (op == aluBGE);
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
interface alu_share_arb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_src1_0;
  logic [DATA_W-1:0] req_src2_0;
  logic [OP_W-1:0]   req_op_0;
  logic [DATA_W-1:0] req_src1_1;
  logic [DATA_W-1:0] req_src2_1;
  logic [OP_W-1:0]   req_op_1;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_result_0;
  logic [DATA_W-1:0] rsp_result_1;
  logic [1:0]        rsp_zero;
  logic              flush_0;

  modport master (
    output req_valid, req_src1_0, req_src2_0, req_op_0,
           req_src1_1, req_src2_1, req_op_1, rsp_ready, flush_0,
    input  req_ready, rsp_valid, rsp_result_0, rsp_result_1, rsp_zero
  );

  modport slave (
    input  req_valid, req_src1_0, req_src2_0, req_op_0,
           req_src1_1, req_src2_1, req_op_1, rsp_ready, flush_0,
    output req_ready, rsp_valid, rsp_result_0, rsp_result_1, rsp_zero
  );

endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
module rr_arb2
  import alu_share_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig_i,
  output logic [1:0] grant_o
);

  owner_e last_q;
  owner_e last_d;

  always_comb begin
    grant_o = '0;
    last_d  = last_q;
    unique case (elig_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_q == OWN_FFT) ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
    if (grant_o[1]) begin
      last_d = OWN_FFT;
    end else if (grant_o[0]) begin
      last_d = OWN_CORE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_FFT;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arb_if.slave    bus,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  logic [1:0]        busy;
  logic [1:0]        elig;
  logic [1:0]        grant;
  logic [1:0]        capture;
  logic              cap_zero;

  logic              iss_valid_q, iss_valid_d;
  owner_e            iss_owner_q, iss_owner_d;
  logic [DATA_W-1:0] iss_src1_q, iss_src1_d;
  logic [DATA_W-1:0] iss_src2_q, iss_src2_d;
  logic [OP_W-1:0]   iss_op_q, iss_op_d;

  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_res0_q, rsp_res0_d;
  logic [DATA_W-1:0] rsp_res1_q, rsp_res1_d;
  logic [1:0]        rsp_zero_q, rsp_zero_d;

  // rst_n gates eligibility so req_ready is 0 for the whole reset, not just after an edge
  always_comb begin
    busy[0] = (iss_valid_q && (iss_owner_q == OWN_CORE)) || rsp_valid_q[0];
    busy[1] = (iss_valid_q && (iss_owner_q == OWN_FFT))  || rsp_valid_q[1];
    elig    = bus.req_valid & ~busy & {2{rst_n}};
    elig[0] = elig[0] & ~bus.flush_0;
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .elig_i  (elig),
    .grant_o (grant)
  );

  assign bus.req_ready = grant;

  always_comb begin
    iss_valid_d = |grant;
    iss_owner_d = iss_owner_q;
    iss_src1_d  = iss_src1_q;
    iss_src2_d  = iss_src2_q;
    iss_op_d    = iss_op_q;
    if (grant[1]) begin
      iss_owner_d = OWN_FFT;
      iss_src1_d  = bus.req_src1_1;
      iss_src2_d  = bus.req_src2_1;
      iss_op_d    = bus.req_op_1;
    end else if (grant[0]) begin
      iss_owner_d = OWN_CORE;
      iss_src1_d  = bus.req_src1_0;
      iss_src2_d  = bus.req_src2_0;
      iss_op_d    = bus.req_op_0;
    end
  end

  always_comb begin
    alu_src1 = iss_valid_q ? iss_src1_q : '0;
    alu_src2 = iss_valid_q ? iss_src2_q : '0;
    alu_op   = iss_valid_q ? iss_op_q   : OP_W'(aluPlus);
  end

  // A flushed core entry still drives the ALU; only its capture is dropped
  always_comb begin
    capture[0] = iss_valid_q && (iss_owner_q == OWN_CORE) && !bus.flush_0;
    capture[1] = iss_valid_q && (iss_owner_q == OWN_FFT);
    cap_zero   = is_branch_op(OP_BITS'(iss_op_q)) && alu_zero;

    rsp_valid_d = rsp_valid_q;
    rsp_res0_d  = rsp_res0_q;
    rsp_res1_d  = rsp_res1_q;
    rsp_zero_d  = rsp_zero_q;

    if (capture[0]) begin
      rsp_valid_d[0] = 1'b1;
      rsp_res0_d     = alu_result;
      rsp_zero_d[0]  = cap_zero;
    end else if (bus.rsp_ready[0] || bus.flush_0) begin
      rsp_valid_d[0] = 1'b0;
    end

    if (capture[1]) begin
      rsp_valid_d[1] = 1'b1;
      rsp_res1_d     = alu_result;
      rsp_zero_d[1]  = cap_zero;
    end else if (bus.rsp_ready[1]) begin
      rsp_valid_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_owner_q <= OWN_CORE;
      iss_src1_q  <= '0;
      iss_src2_q  <= '0;
      iss_op_q    <= OP_W'(aluPlus);
      rsp_valid_q <= '0;
      rsp_res0_q  <= '0;
      rsp_res1_q  <= '0;
      rsp_zero_q  <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_owner_q <= iss_owner_d;
      iss_src1_q  <= iss_src1_d;
      iss_src2_q  <= iss_src2_d;
      iss_op_q    <= iss_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res0_q  <= rsp_res0_d;
      rsp_res1_q  <= rsp_res1_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result_0 = rsp_res0_q;
  assign bus.rsp_result_1 = rsp_res1_q;
  assign bus.rsp_zero     = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [32:0] alu_out;

  int unsigned errors;
  int unsigned checks;

  alu_share_arb_if #(.DATA_W(32), .OP_W(4)) bus ();

  alu_share_arb #(.DATA_W(32), .OP_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic br_op(input logic [3:0] op);
    return op inside {aluBEQ, aluBNE, aluBLT, aluBGE};
  endfunction

  // Behavioural ALU: {zero, result}; zero is "branch taken" for compares, result==0 otherwise
  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        z;
    r = '0;
    z = 1'b0;
    case (op)
      aluPlus: r = a + b;
      aluSub:  r = a - b;
      aluAnd:  r = a & b;
      aluOr:   r = a | b;
      aluXor:  r = a ^ b;
      aluSll:  r = a << b[4:0];
      aluSrl:  r = a >> b[4:0];
      aluSra:  r = 32'($signed(a) >>> b[4:0]);
      aluSlt:  r = {31'd0, $signed(a) < $signed(b)};
      aluSltu: r = {31'd0, a < b};
      aluBEQ:  begin r = a - b; z = (a == b); end
      aluBNE:  begin r = a - b; z = (a != b); end
      aluBLT:  begin r = a - b; z = ($signed(a) < $signed(b)); end
      aluBGE:  begin r = a - b; z = ($signed(a) >= $signed(b)); end
      default: r = '0;
    endcase
    if (!br_op(op)) z = (r == 32'd0);
    return {z, r};
  endfunction

  assign alu_out    = alu_ref(alu_op, alu_src1, alu_src2);
  assign alu_result = alu_out[31:0];
  assign alu_zero   = alu_out[32];

  // Transaction-level model: one outstanding op per requester, tagged with its accept cycle
  bit          out_v[2];
  int          acc_c[2];
  logic [31:0] m_s1[2];
  logic [31:0] m_s2[2];
  logic [3:0]  m_op[2];
  logic [31:0] m_res[2];
  logic        m_zero[2];
  logic [31:0] last_res[2];
  logic        last_zero[2];
  int          last_g;
  int          cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      out_v[i]     = 1'b0;
      last_res[i]  = '0;
      last_zero[i] = 1'b0;
    end
    last_g = 1;
  endtask

  task automatic check_reset(input string p);
    check_eq({p, "_rdy"},  32'(bus.req_ready), 32'd0);
    check_eq({p, "_rv"},   32'(bus.rsp_valid), 32'd0);
    check_eq({p, "_res0"}, bus.rsp_result_0, 32'd0);
    check_eq({p, "_res1"}, bus.rsp_result_1, 32'd0);
    check_eq({p, "_zero"}, 32'(bus.rsp_zero), 32'd0);
    check_eq({p, "_s1"},   alu_src1, 32'd0);
    check_eq({p, "_s2"},   alu_src2, 32'd0);
    check_eq({p, "_op"},   32'(alu_op), 32'(aluPlus));
  endtask

  task automatic step(input logic [1:0] v,
                      input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] o0,
                      input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] o1,
                      input logic [1:0] rr, input logic fl);
    logic [1:0]  el;
    logic [1:0]  g;
    logic [1:0]  vis;
    logic [1:0]  ez;
    logic [31:0] es1;
    logic [31:0] es2;
    logic [3:0]  eop;
    logic [32:0] ar;
    int          k;
    @(negedge clk);
    bus.req_valid  = v;
    bus.req_src1_0 = a0;
    bus.req_src2_0 = b0;
    bus.req_op_0   = o0;
    bus.req_src1_1 = a1;
    bus.req_src2_1 = b1;
    bus.req_op_1   = o1;
    bus.rsp_ready  = rr;
    bus.flush_0    = fl;
    #1;
    es1 = '0;
    es2 = '0;
    eop = aluPlus;
    for (int i = 0; i < 2; i++) begin
      vis[i] = out_v[i] && (cyc >= acc_c[i] + 2);
      el[i]  = v[i] && !out_v[i];
      ez[i]  = last_zero[i];
      if (out_v[i] && (cyc == acc_c[i] + 1)) begin
        es1 = m_s1[i];
        es2 = m_s2[i];
        eop = m_op[i];
      end
    end
    if (fl) el[0] = 1'b0;
    if (el == 2'b11) g = (last_g == 1) ? 2'b01 : 2'b10;
    else             g = el;

    check_eq("req_ready", 32'(bus.req_ready), 32'(g));
    check_eq("alu_src1", alu_src1, es1);
    check_eq("alu_src2", alu_src2, es2);
    check_eq("alu_op", 32'(alu_op), 32'(eop));
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(vis));
    check_eq("rsp_result_0", bus.rsp_result_0, last_res[0]);
    check_eq("rsp_result_1", bus.rsp_result_1, last_res[1]);
    check_eq("rsp_zero", 32'(bus.rsp_zero), 32'(ez));

    for (int i = 0; i < 2; i++) begin
      if (out_v[i] && (cyc == acc_c[i] + 1) && !(i == 0 && fl)) begin
        last_res[i]  = m_res[i];
        last_zero[i] = m_zero[i];
      end
      if (vis[i] && rr[i]) out_v[i] = 1'b0;
    end
    if (fl) out_v[0] = 1'b0;
    if (g != 2'b00) begin
      k = g[1] ? 1 : 0;
      out_v[k] = 1'b1;
      acc_c[k] = cyc;
      m_s1[k]  = k ? a1 : a0;
      m_s2[k]  = k ? b1 : b0;
      m_op[k]  = k ? o1 : o0;
      ar       = alu_ref(m_op[k], m_s1[k], m_s2[k]);
      m_res[k] = ar[31:0];
      m_zero[k] = br_op(m_op[k]) ? ar[32] : 1'b0;
      last_g   = k;
    end
    cyc++;
  endtask

  task automatic idle(input int unsigned n, input logic [1:0] rr);
    for (int unsigned i = 0; i < n; i++) step(2'b00, '0, '0, aluPlus, '0, '0, aluPlus, rr, 1'b0);
  endtask

  initial begin
    logic [1:0]  v;
    logic [1:0]  rr;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  o0, o1;
    logic        fl;

    errors = 0;
    checks = 0;
    cyc    = 0;
    rst_n  = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_src1_0 = 32'h1;
    bus.req_src2_0 = 32'h2;
    bus.req_op_0   = aluSub;
    bus.req_src1_1 = 32'h3;
    bus.req_src2_1 = 32'h4;
    bus.req_op_1   = aluXor;
    bus.rsp_ready  = 2'b00;
    bus.flush_0    = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset("reset");
    bus.req_valid = 2'b00;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single core op, 2-cycle latency
    step(2'b01, 32'd5, 32'd7, aluPlus, '0, '0, aluPlus, 2'b11, 1'b0);
    idle(2, 2'b11);
    check_eq("t1_result", bus.rsp_result_0, 32'd12);
    check_eq("t1_valid", 32'(bus.rsp_valid), 32'd1);
    idle(1, 2'b11);

    // Both requesters continuously valid
    for (int unsigned i = 0; i < 10; i++)
      step(2'b11, 32'd100 + i, 32'd3, aluSub, 32'd7 * i, 32'd2, aluSll, 2'b11, 1'b0);
    idle(3, 2'b11);

    // Branch compare flag on requester 1
    step(2'b10, '0, '0, aluPlus, 32'h10, 32'h10, aluBEQ, 2'b11, 1'b0);
    idle(2, 2'b11);
    check_eq("t3_beq_zero", 32'(bus.rsp_zero[1]), 32'd1);
    step(2'b10, '0, '0, aluPlus, 32'd3, 32'd3, aluBNE, 2'b11, 1'b0);
    idle(2, 2'b11);
    check_eq("t3_bne_zero", 32'(bus.rsp_zero[1]), 32'd0);
    step(2'b10, '0, '0, aluPlus, 32'd9, 32'd4, aluSub, 2'b11, 1'b0);
    idle(2, 2'b11);
    check_eq("t3_sub_res", bus.rsp_result_1, 32'd5);
    check_eq("t3_sub_zero", 32'(bus.rsp_zero[1]), 32'd0);
    idle(1, 2'b11);

    // Core response held under backpressure while FFT keeps issuing
    step(2'b01, 32'hA5A5_0000, 32'h0000_5A5A, aluOr, '0, '0, aluPlus, 2'b00, 1'b0);
    for (int unsigned i = 0; i < 6; i++)
      step(2'b11, 32'd1, 32'd1, aluPlus, 32'd40 + i, 32'd1, aluPlus, 2'b10, 1'b0);
    check_eq("t4_held", bus.rsp_result_0, 32'hA5A5_5A5A);
    idle(2, 2'b11);

    // Flush kills an accepted core op
    step(2'b01, 32'd11, 32'd22, aluPlus, '0, '0, aluPlus, 2'b11, 1'b0);
    step(2'b11, 32'd1, 32'd2, aluPlus, 32'd8, 32'd8, aluBEQ, 2'b11, 1'b1);
    step(2'b01, 32'd30, 32'd4, aluSub, '0, '0, aluPlus, 2'b11, 1'b0);
    idle(3, 2'b11);

    // Asynchronous reset with issue stage and a response register occupied
    step(2'b01, 32'd77, 32'd1, aluPlus, '0, '0, aluPlus, 2'b00, 1'b0);
    step(2'b10, '0, '0, aluPlus, 32'd5, 32'd6, aluAnd, 2'b00, 1'b0);
    bus.req_valid = 2'b11;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    bus.req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    idle(3, 2'b11);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      v  = 2'($urandom_range(0, 3));
      a0 = $urandom;
      b0 = ($urandom_range(0, 1) == 0) ? a0 : $urandom;
      o0 = 4'($urandom_range(0, 13));
      a1 = $urandom;
      b1 = ($urandom_range(0, 1) == 0) ? a1 : $urandom;
      o1 = 4'($urandom_range(0, 13));
      rr[0] = ($urandom_range(0, 3) != 0);
      rr[1] = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 9) == 0);
      step(v, a0, b0, o0, a1, b1, o1, rr, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
